lia_sweep_controller: RTL and testbench
=======================================

Name: lia_sweep_controller

Overview:
Frequency-sweep sequencer for lia_digital_core. Programs the NCO phase_increment for each sweep point and discards mixer output while the mixer settles. It then averages a power-of-two block of mixer I/Q samples and hands one averaged result per point downstream over a valid/ready handshake. It sits between the host/config registers and the core, owning phase_increment.

Parameters:
DATA_W, 24, width of mixer_i_in/mixer_q_in and res_i/res_q (signed)
LOG2_AVG, 6, averaging block = 2**LOG2_AVG valid mixer samples per point
SETTLE_SAMPLES, 32, valid mixer samples discarded after each frequency change (0 allowed)
PTS_W, 16, width of point count/index

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle sweep start request; honoured only in IDLE
abort  in  1  cancel sweep; wins over all other inputs except rst
start_freq  in  32  phase increment of point 0
step_freq  in  32  phase increment added per point (mod 2**32)
num_points  in  PTS_W  number of sweep points
phase_increment  out  32  to core NCO
mixer_i_in  in  DATA_W  signed core I output
mixer_q_in  in  DATA_W  signed core Q output
mixer_valid_in  in  1  core output qualifier
res_i  out  DATA_W  signed averaged I
res_q  out  DATA_W  signed averaged Q
res_index  out  PTS_W  point index of current result
res_valid  out  1  result valid
res_ready  in  1  downstream accept
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset: state IDLE; phase_increment, res_i, res_q, res_index, counters and accumulators = 0; res_valid, busy, done = 0.
- Inputs start_freq, step_freq and num_points are sampled on the start cycle. Later changes have no effect on the running sweep.
- States and transitions:
  - IDLE: on start with num_points != 0, load phase_increment <= start_freq and idx <= 0, go to SETTLE. On start with num_points == 0, go to DONE.
  - SETTLE: count mixer_valid_in beats. After SETTLE_SAMPLES beats, clear the accumulators and go to ACQUIRE. With SETTLE_SAMPLES == 0, go to ACQUIRE on the next cycle.
  - ACQUIRE: on each mixer_valid_in, acc_i += sign-extended I and acc_q += sign-extended Q. Accumulator width is DATA_W+LOG2_AVG, so it cannot overflow. On the 2**LOG2_AVG-th beat, register res_i = (acc_i incl. that beat) >>> LOG2_AVG (arithmetic shift, truncating toward -inf), same for res_q. Set res_index = idx and go to OUTPUT with res_valid = 1 the next cycle.
  - OUTPUT: hold res_valid and all res_* stable until res_ready. Mixer beats arriving here are ignored. On handshake:
    - last point (idx == num_points-1): go to DONE.
    - otherwise: phase_increment += step_freq (wraps mod 2**32), idx += 1, go to SETTLE.
  - res_valid falls the cycle after handshake.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- phase_increment changes only on a LOAD or step transition and holds its value in IDLE after the sweep ends.
- start while busy: ignored.
- abort (any non-IDLE state): next cycle IDLE, res_valid = 0, busy = 0, no done pulse, phase_increment retains its current value. Simultaneous abort + res_ready: no step, transfer counts as accepted.
- start and abort in the same cycle in IDLE: start ignored.
- rst mid-sweep: all outputs return to their reset values on the next edge.

Optional Feature:
LIA_SWEEP_PEAK_EN: when defined, adds outputs peak_index (PTS_W) and peak_mag (DATA_W+1).
- For each accepted result, compute mag = |res_i| + |res_q| (unsigned, DATA_W+1 bits).
- Cleared on start. Updated on handshake when mag > peak_mag (strict; the first point always loads). Ties keep the earlier index. Values are valid when done pulses.
- Undefined: ports absent, no logic.

Decomposition:
- Package lia_pkg holds:
  - state enum (IDLE, SETTLE, ACQUIRE, OUTPUT, DONE)
  - PHASE_W = 32
  - default DATA_W and LOG2_AVG
- One sub-module, lia_iq_averager, handles accumulate/clear/shift for both channels with a done-beat flag. The FSM stays in the top module.

Test Plan:
- Basic sweep: start_freq=858993459, step=1000, num_points=3, SETTLE=32, LOG2_AVG=6, constant I=100, Q=-100, mixer_valid every cycle -> 3 results (100, -100) with indices 0, 1, 2; phase_increment sequence 858993459, 858994459, 858995459; single done pulse.
- Averaging rounding: alternating I=3, I=4 over 64 beats -> res_i=3. All I=-1 -> res_i=-1. Alternating -1/-2 -> -2.
- Backpressure: res_ready held low 20 cycles -> res_valid and res_* stable, phase_increment unchanged, mixer beats ignored.
- Wrap and gaps: start_freq=32'hFFFF_FF00, step=32'h200, mixer_valid 1-in-4 -> point 1 phase = 32'h0000_0100, result still from exactly 64 valid beats.
- Abort in ACQUIRE: busy falls next cycle, no result, no done. A new start re-runs cleanly from point 0.
- Edge cases: num_points=0 -> done pulse 2 cycles after start, no res_valid. With LIA_SWEEP_PEAK_EN, results (10, 0), (-50, 20), (30, 40) -> peak_index=1, peak_mag=70.

Source files
------------

// File: rtl/lia_pkg.sv
// Shared types and defaults for the lock-in sweep controller slice.
// Holds the controller state enum, the NCO phase width and the default
// mixer data width / averaging depth used by the sweep blocks.
package lia_pkg;

  localparam int PHASE_W      = 32;
  localparam int DEF_DATA_W   = 24;
  localparam int DEF_LOG2_AVG = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ACQUIRE = 3'd2,
    OUTPUT  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/lia_sweep_controller_if.sv
// Result channel of the sweep controller: one averaged I/Q pair per sweep
// point with its index, moved on a valid/ready handshake.
// Ports: res_i/res_q (signed averages), res_index, res_valid, res_ready.
// master = controller side (drives data/valid), slave = downstream consumer.
interface lia_sweep_controller_if
  import lia_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PTS_W  = 16
);

  logic signed [DATA_W-1:0] res_i;
  logic signed [DATA_W-1:0] res_q;
  logic        [PTS_W-1:0]  res_index;
  logic                     res_valid;
  logic                     res_ready;

  modport master (
    output res_i, res_q, res_index, res_valid,
    input  res_ready
  );

  modport slave (
    input  res_i, res_q, res_index, res_valid,
    output res_ready
  );

endinterface

// File: rtl/lia_iq_averager.sv
// Purpose: block-average 2**LOG2_AVG signed I/Q beats (accumulate, clear, shift).
// Latency: avg_i/avg_q/last are combinational on the final beat (include it).
// Backpressure: none; the caller gates beats with the beat input.
// Ports: clk, rst, clear (zero accumulators/count), beat (accept in_i/in_q),
//        avg_i/avg_q (floor((acc + in) / 2**LOG2_AVG)), last (final beat of block).
module lia_iq_averager
  import lia_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOG2_AVG = DEF_LOG2_AVG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     beat,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  output logic signed [DATA_W-1:0] avg_i,
  output logic signed [DATA_W-1:0] avg_q,
  output logic                     last
);

  // LOG2_AVG guard bits make overflow impossible for a full block.
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic        [CNT_W-1:0] cnt;

  always_comb begin
    sum_i = acc_i + ACC_W'(in_i);
    sum_q = acc_q + ACC_W'(in_q);
    // Arithmetic shift floors toward -inf, matching a truncating divide for >= 0.
    avg_i = DATA_W'(sum_i >>> LOG2_AVG);
    avg_q = DATA_W'(sum_q >>> LOG2_AVG);
    last  = beat && (cnt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (beat) begin
      if (last) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lia_sweep_controller.sv
// Purpose: frequency-sweep sequencer; programs NCO phase_increment per point,
//          discards SETTLE_SAMPLES mixer beats, then averages 2**LOG2_AVG beats.
// Latency: result valid the cycle after the final averaged beat; done one cycle after DONE entry.
// Backpressure: res holds stable until res_ready; mixer beats are dropped meanwhile.
// Ports: clk, rst (sync, active-high), start/abort, start_freq/step_freq/num_points
//        (sampled on start), phase_increment (to NCO), mixer_i_in/mixer_q_in/
//        mixer_valid_in (from core), res (result channel, master), busy, done.
// Optional: define LIA_SWEEP_PEAK_EN to add peak_index/peak_mag (largest |I|+|Q|).
module lia_sweep_controller
  import lia_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LOG2_AVG       = DEF_LOG2_AVG,
  parameter int SETTLE_SAMPLES = 32,
  parameter int PTS_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PHASE_W-1:0]       start_freq,
  input  logic [PHASE_W-1:0]       step_freq,
  input  logic [PTS_W-1:0]         num_points,
  output logic [PHASE_W-1:0]       phase_increment,
  input  logic signed [DATA_W-1:0] mixer_i_in,
  input  logic signed [DATA_W-1:0] mixer_q_in,
  input  logic                     mixer_valid_in,
  lia_sweep_controller_if.master   res,
  output logic                     busy,
  output logic                     done
`ifdef LIA_SWEEP_PEAK_EN
  ,
  output logic [PTS_W-1:0]         peak_index,
  output logic [DATA_W:0]          peak_mag
`endif
);

  localparam int SET_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST =
      SET_W'((SETTLE_SAMPLES > 0) ? (SETTLE_SAMPLES - 1) : 0);

  state_t               state;
  logic [PTS_W-1:0]     idx;
  logic [PTS_W-1:0]     npts;
  logic [PHASE_W-1:0]   step_q;
  logic [SET_W-1:0]     settle_cnt;

  logic                     avg_clear, avg_beat, avg_last;
  logic signed [DATA_W-1:0] avg_i, avg_q;

  // Accumulators sit at zero outside ACQUIRE, so entering ACQUIRE always starts a fresh block.
  assign avg_clear = (state != ACQUIRE);
  assign avg_beat  = (state == ACQUIRE) && mixer_valid_in && !abort;

  lia_iq_averager #(
    .DATA_W   (DATA_W),
    .LOG2_AVG (LOG2_AVG)
  ) u_avg (
    .clk   (clk),
    .rst   (rst),
    .clear (avg_clear),
    .beat  (avg_beat),
    .in_i  (mixer_i_in),
    .in_q  (mixer_q_in),
    .avg_i (avg_i),
    .avg_q (avg_q),
    .last  (avg_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      phase_increment <= '0;
      res.res_i       <= '0;
      res.res_q       <= '0;
      res.res_index   <= '0;
      res.res_valid   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      idx             <= '0;
      npts            <= '0;
      step_q          <= '0;
      settle_cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // phase_increment deliberately left at the point being measured.
        state         <= IDLE;
        busy          <= 1'b0;
        res.res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              step_q <= step_freq;
              npts   <= num_points;
              busy   <= 1'b1;
              if (num_points != '0) begin
                phase_increment <= start_freq;
                idx             <= '0;
                settle_cnt      <= '0;
                state           <= SETTLE;
              end else begin
                state <= DONE;
              end
            end
          end
          SETTLE: begin
            if (SETTLE_SAMPLES == 0) begin
              state <= ACQUIRE;
            end else if (mixer_valid_in) begin
              if (settle_cnt == SET_LAST) begin
                settle_cnt <= '0;
                state      <= ACQUIRE;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          ACQUIRE: begin
            if (avg_last) begin
              res.res_i     <= avg_i;
              res.res_q     <= avg_q;
              res.res_index <= idx;
              res.res_valid <= 1'b1;
              state         <= OUTPUT;
            end
          end
          OUTPUT: begin
            if (res.res_ready) begin
              res.res_valid <= 1'b0;
              if (idx == npts - PTS_W'(1)) begin
                state <= DONE;
              end else begin
                phase_increment <= phase_increment + step_q;
                idx             <= idx + 1'b1;
                settle_cnt      <= '0;
                state           <= SETTLE;
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LIA_SWEEP_PEAK_EN
  logic [DATA_W-1:0] abs_i, abs_q;
  logic [DATA_W:0]   mag;

  // Negating the most negative value yields its exact magnitude when read unsigned.
  always_comb begin
    abs_i = res.res_i[DATA_W-1] ? DATA_W'(-res.res_i) : DATA_W'(res.res_i);
    abs_q = res.res_q[DATA_W-1] ? DATA_W'(-res.res_q) : DATA_W'(res.res_q);
    mag   = {1'b0, abs_i} + {1'b0, abs_q};
  end

  // Strict compare keeps the earliest index on ties; an accepted transfer
  // that coincides with abort still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_index <= '0;
      peak_mag   <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      peak_index <= '0;
      peak_mag   <= '0;
    end else if ((state == OUTPUT) && res.res_ready && (mag > peak_mag)) begin
      peak_index <= res.res_index;
      peak_mag   <= mag;
    end
  end
`endif

endmodule

// File: tb/tb_lia_sweep_controller.sv
// Self-checking bench for lia_sweep_controller: randomized mixer/handshake
// stimulus against a point/beat-level reference model, plus literal checks.
module tb_lia_sweep_controller;

  localparam int DW   = 24;
  localparam int LA   = 6;
  localparam int SS   = 32;
  localparam int PW   = 16;
  localparam int NAVG = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [31:0]          start_freq = '0;
  logic [31:0]          step_freq = '0;
  logic [PW-1:0]        num_points = '0;
  logic [31:0]          phase_increment;
  logic signed [DW-1:0] mixer_i_in = '0;
  logic signed [DW-1:0] mixer_q_in = '0;
  logic                 mixer_valid_in = 1'b0;
  logic                 res_ready = 1'b0;
  logic                 busy, done;
`ifdef LIA_SWEEP_PEAK_EN
  logic [PW-1:0]        peak_index;
  logic [DW:0]          peak_mag;
`endif

  lia_sweep_controller_if #(.DATA_W(DW), .PTS_W(PW)) rif ();
  assign rif.res_ready = res_ready;

  lia_sweep_controller #(
    .DATA_W(DW), .LOG2_AVG(LA), .SETTLE_SAMPLES(SS), .PTS_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_freq(start_freq), .step_freq(step_freq), .num_points(num_points),
    .phase_increment(phase_increment),
    .mixer_i_in(mixer_i_in), .mixer_q_in(mixer_q_in), .mixer_valid_in(mixer_valid_in),
    .res(rif), .busy(busy), .done(done)
`ifdef LIA_SWEEP_PEAK_EN
    , .peak_index(peak_index), .peak_mag(peak_mag)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (points and beats, not states) ----------
  int          cyc_n = 0;
  bit          m_busy, m_fin, m_coll, m_rv, m_done;
  logic [31:0] m_phase, m_step;
  int          m_idx, m_npts, m_seen, m_cnt;
  longint      m_si, m_sq;
  int          m_ri, m_rq, m_rx;
  int          m_pk_idx, m_pk_mag;

  function automatic int floor_div(input longint s);
    longint q;
    q = s / NAVG;
    if (s < 0 && (s % NAVG) != 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic begin_point();
    m_seen = 0; m_cnt = 0; m_si = 0; m_sq = 0; m_coll = 1;
  endtask

  task automatic peak_upd();
    int mag;
    mag = (m_ri < 0 ? -m_ri : m_ri) + (m_rq < 0 ? -m_rq : m_rq);
    if (mag > m_pk_mag) begin
      m_pk_mag = mag;
      m_pk_idx = m_rx;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
    if (rst) begin
      m_busy = 0; m_fin = 0; m_coll = 0; m_rv = 0; m_done = 0;
      m_phase = 0; m_step = 0; m_idx = 0; m_npts = 0;
      m_ri = 0; m_rq = 0; m_rx = 0; m_pk_idx = 0; m_pk_mag = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_pk_idx = 0; m_pk_mag = 0;
          m_busy = 1; m_npts = int'(num_points); m_step = step_freq;
          if (num_points == 0) m_fin = 1;
          else begin
            m_phase = start_freq; m_idx = 0; begin_point();
          end
        end
      end else if (abort) begin
        if (m_rv && res_ready) peak_upd();
        m_busy = 0; m_rv = 0; m_fin = 0; m_coll = 0;
      end else if (m_fin) begin
        m_fin = 0; m_busy = 0; m_done = 1;
      end else if (m_rv) begin
        if (res_ready) begin
          peak_upd();
          m_rv = 0;
          if (m_idx == m_npts - 1) m_fin = 1;
          else begin
            m_phase = m_phase + m_step; m_idx++; begin_point();
          end
        end
      end else if (m_coll && mixer_valid_in) begin
        m_seen++;
        if (m_seen > SS) begin
          m_si += longint'(mixer_i_in);
          m_sq += longint'(mixer_q_in);
          m_cnt++;
          if (m_cnt == NAVG) begin
            m_ri = floor_div(m_si); m_rq = floor_div(m_sq); m_rx = m_idx;
            m_rv = 1; m_coll = 0;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_en = 0;
  int cap_i[$], cap_q[$], cap_x[$];
  logic [31:0] cap_ph[$];
  int done_cnt = 0, done_cyc = 0, start_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("res_valid", rif.res_valid, m_rv);
      chk("phase", phase_increment, m_phase);
      if (m_rv) begin
        chk("res_i", rif.res_i, m_ri);
        chk("res_q", rif.res_q, m_rq);
        chk("res_index", rif.res_index, m_rx);
      end
      if (rif.res_valid && res_ready) begin
        cap_i.push_back(int'(rif.res_i));
        cap_q.push_back(int'(rif.res_q));
        cap_x.push_back(int'(rif.res_index));
        cap_ph.push_back(phase_increment);
      end
      if (start) start_cyc = cyc_n;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
`ifdef LIA_SWEEP_PEAK_EN
        chk("peak_index", peak_index, m_pk_idx);
        chk("peak_mag", peak_mag, m_pk_mag);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  int vld_pct = 100, dmode = 0, rmode = 0, abort_pm = 0;
  int c_i = 0, c_q = 0, a_i = 0, hold_n = 0;
  bit alt_ph = 0, stray_en = 0;
  int tab_i[3] = '{10, -50, 30};
  int tab_q[3] = '{0, 20, 40};

  task automatic tick();
    @(posedge clk);
    #1;
    start = 0;
    abort = 0;
    mixer_valid_in = ($urandom_range(0, 99) < vld_pct);
    if (mixer_valid_in) alt_ph = ~alt_ph;
    case (dmode)
      0: begin mixer_i_in = DW'(c_i); mixer_q_in = DW'(c_q); end
      1: begin mixer_i_in = DW'(alt_ph ? c_i : a_i); mixer_q_in = DW'(c_q); end
      2: begin mixer_i_in = DW'($urandom); mixer_q_in = DW'($urandom); end
      default: begin mixer_i_in = DW'(tab_i[m_idx % 3]); mixer_q_in = DW'(tab_q[m_idx % 3]); end
    endcase
    case (rmode)
      0: res_ready = 1;
      1: res_ready = 1'($urandom_range(0, 1));
      default: begin
        if (rif.res_valid) begin
          if (hold_n < 20) begin res_ready = 0; hold_n++; end
          else res_ready = 1;
        end else begin
          hold_n = 0; res_ready = 0;
        end
      end
    endcase
    if (stray_en && busy && m_busy && $urandom_range(0, 99) < 5) begin
      start = 1; start_freq = $urandom; step_freq = $urandom;
    end
    if (abort_pm > 0 && busy && $urandom_range(0, 999) < abort_pm) abort = 1;
  endtask

  task automatic clear_caps();
    cap_i.delete(); cap_q.delete(); cap_x.delete(); cap_ph.delete();
    done_cnt = 0;
  endtask

  task automatic run_sweep(input logic [31:0] sf, input logic [31:0] st, input int np);
    int n;
    clear_caps();
    start_freq = sf; step_freq = st; num_points = PW'(np);
    start = 1;
    tick();
    // later changes must not affect the running sweep
    start_freq = $urandom; step_freq = $urandom; num_points = PW'($urandom);
    n = 0;
    while ((busy || m_busy) && n < 6000) begin tick(); n++; end
    chk("sweep_ends", (n < 6000) ? 1 : 0, 1);
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(); chk_en = 1; tick(); tick();
    chk("rst_phase", phase_increment, 0);
    chk("rst_res_valid", rif.res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_i", rif.res_i, 0);
    chk("rst_res_q", rif.res_q, 0);
    chk("rst_res_index", rif.res_index, 0);
    rst = 0;
    tick();

    // basic sweep
    dmode = 0; c_i = 100; c_q = -100; vld_pct = 100; rmode = 0;
    run_sweep(32'd858993459, 32'd1000, 3);
    chk("basic_count", cap_i.size(), 3);
    if (cap_i.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("basic_i", cap_i[k], 100);
        chk("basic_q", cap_q[k], -100);
        chk("basic_index", cap_x[k], k);
      end
      chk("basic_ph0", cap_ph[0], 858993459);
      chk("basic_ph1", cap_ph[1], 858994459);
      chk("basic_ph2", cap_ph[2], 858995459);
    end
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_phase_held", phase_increment, 858995459);

    // averaging rounding
    dmode = 1; c_i = 4; a_i = 3; c_q = 0;
    run_sweep(32'd5, 32'd0, 1);
    chk("round_3_4", (cap_i.size() == 1) ? cap_i[0] : 999, 3);
    dmode = 0; c_i = -1;
    run_sweep(32'd5, 32'd0, 1);
    chk("round_m1", (cap_i.size() == 1) ? cap_i[0] : 999, -1);
    dmode = 1; c_i = -1; a_i = -2;
    run_sweep(32'd5, 32'd0, 1);
    chk("round_m1_m2", (cap_i.size() == 1) ? cap_i[0] : 999, -2);

    // backpressure with random data
    dmode = 2; rmode = 2; vld_pct = 70;
    run_sweep(32'h1234_5678, 32'h10, 2);
    chk("bp_count", cap_i.size(), 2);

    // wrap and sparse valid
    rmode = 1; vld_pct = 25;
    run_sweep(32'hFFFF_FF00, 32'h200, 2);
    chk("wrap_count", cap_ph.size(), 2);
    if (cap_ph.size() == 2) begin
      chk("wrap_ph0", cap_ph[0], 32'hFFFF_FF00);
      chk("wrap_ph1", cap_ph[1], 32'h0000_0100);
    end

    // abort in ACQUIRE then clean re-run
    dmode = 0; c_i = 100; c_q = -100; vld_pct = 100; rmode = 0;
    clear_caps();
    start_freq = 32'd858993459; step_freq = 32'd1000; num_points = 3;
    start = 1;
    tick();
    n = 0;
    while (!(m_coll && m_seen > SS + 10) && n < 500) begin tick(); n++; end
    chk("abort_reach_acq", (n < 500) ? 1 : 0, 1);
    abort = 1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_phase", phase_increment, 858993459);
    for (int k = 0; k < 80; k++) tick();
    chk("abort_no_result", cap_i.size(), 0);
    chk("abort_no_done", done_cnt, 0);
    run_sweep(32'd7000, 32'd3, 2);
    chk("rerun_count", cap_x.size(), 2);
    if (cap_x.size() == 2) begin
      chk("rerun_idx0", cap_x[0], 0);
      chk("rerun_i0", cap_i[0], 100);
      chk("rerun_ph0", cap_ph[0], 7000);
      chk("rerun_ph1", cap_ph[1], 7003);
    end

    // zero points
    run_sweep(32'd42, 32'd1, 0);
    chk("np0_done_delay", done_cyc - start_cyc, 2);
    chk("np0_done_pulses", done_cnt, 1);
    chk("np0_no_result", cap_i.size(), 0);

`ifdef LIA_SWEEP_PEAK_EN
    dmode = 3;
    run_sweep(32'd100, 32'd100, 3);
    chk("peak_lit_index", peak_index, 1);
    chk("peak_lit_mag", peak_mag, 70);
`endif

    // randomized sweeps with stray starts and occasional aborts
    dmode = 2; rmode = 1; stray_en = 1; abort_pm = 2;
    for (int r = 0; r < 4; r++) begin
      vld_pct = $urandom_range(30, 100);
      run_sweep($urandom, $urandom, $urandom_range(1, 3));
    end
    stray_en = 0; abort_pm = 0;

    // reset mid-sweep
    start_freq = 32'h55; step_freq = 32'h1; num_points = 2;
    start = 1;
    tick();
    for (int k = 0; k < 50; k++) tick();
    rst = 1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_phase", phase_increment, 0);
    rst = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
